// File: rtl/hot_query_scheduler.sv
// Periodic hot-page query scheduler: polls the sampling tracker every cfg_epoch cycles,
// drops back-to-back duplicate candidates and hands the rest to the migration engine.
module hot_query_scheduler #(
  parameter int ADDR_SIZE = 22,
  parameter int EPOCH_W   = 16,
  parameter int TIMEOUT   = 8,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_enable,
  input  logic [EPOCH_W-1:0]   cfg_epoch,
  output logic                 query_en,
  input  logic                 query_ready,
  input  logic                 mig_addr_en,
  input  logic [ADDR_SIZE-1:0] mig_addr,
  output logic                 mig_addr_ready,
  output logic                 out_valid,
  output logic [ADDR_SIZE-1:0] out_addr,
  input  logic                 out_ready,
  output logic [STAT_W-1:0]    stat_issued,
  output logic [STAT_W-1:0]    stat_dup,
  output logic [STAT_W-1:0]    stat_timeout,
  output logic                 busy
);

  localparam int TO_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, COUNT, QUERY, WAIT, HOLD} state_t;

  state_t                 state_q;
  logic [EPOCH_W-1:0]     epoch_cnt_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic                   last_vld_q;
  logic [ADDR_SIZE-1:0]   last_addr_q;
  logic [ADDR_SIZE-1:0]   out_addr_q;
  logic                   out_valid_q;
  logic [STAT_W-1:0]      stat_issued_q;
  logic [STAT_W-1:0]      stat_dup_q;
  logic [STAT_W-1:0]      stat_timeout_q;

  logic epoch_hit;
  logic to_last;
  logic is_dup;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign epoch_hit = (epoch_cnt_q == EPOCH_W'(cfg_epoch - 1'b1));
  // Last WAIT cycle: a response arriving here still wins over the timeout.
  assign to_last   = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign is_dup    = last_vld_q && (mig_addr == last_addr_q);

  // Gating with cfg_enable keeps a disable in QUERY from leaking a strobe.
  assign query_en       = (state_q == QUERY) && query_ready && cfg_enable;
  assign mig_addr_ready = (state_q == WAIT);
  assign busy           = (state_q != IDLE);
  assign out_valid      = out_valid_q;
  assign out_addr       = out_addr_q;
  assign stat_issued    = stat_issued_q;
  assign stat_dup       = stat_dup_q;
  assign stat_timeout   = stat_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      epoch_cnt_q    <= '0;
      to_cnt_q       <= '0;
      last_vld_q     <= 1'b0;
      last_addr_q    <= '0;
      out_addr_q     <= '0;
      out_valid_q    <= 1'b0;
      stat_issued_q  <= '0;
      stat_dup_q     <= '0;
      stat_timeout_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_enable && (cfg_epoch != '0)) begin
            state_q     <= COUNT;
            epoch_cnt_q <= '0;
          end
        end
        COUNT: begin
          epoch_cnt_q <= epoch_cnt_q + 1'b1;
          if (!cfg_enable || (cfg_epoch == '0)) begin
            state_q <= IDLE;
          end else if (epoch_hit) begin
            state_q <= QUERY;
          end
        end
        QUERY: begin
          if (!cfg_enable) begin
            state_q <= IDLE;
          end else if (query_ready) begin
            state_q  <= WAIT;
            to_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (mig_addr_en) begin
            if (is_dup) begin
              stat_dup_q <= sat_inc(stat_dup_q);
              state_q    <= IDLE;
            end else begin
              out_addr_q  <= mig_addr;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end else if (to_last) begin
            stat_timeout_q <= sat_inc(stat_timeout_q);
            state_q        <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q   <= 1'b0;
            last_addr_q   <= out_addr_q;
            last_vld_q    <= 1'b1;
            stat_issued_q <= sat_inc(stat_issued_q);
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
